// File: rtl/hwpe_ctrl_nloop.sv
// -----------------------------------------------------------------------------
// hwpe_ctrl_nloop
//
// Nested-loop offset generator for HWPE controllers. Walks up to NB_LOOPS
// nested counters (loop 0 innermost) and produces NB_CH address offsets per
// iteration. When loop l increments, every channel adds its own signed stride
// for loop l; wrapping inner loops contribute nothing, so software encodes any
// rewind in the stride of the next outer loop. One tuple per handshake.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         synchronous soft clear (aborts a run, no done pulse)
//   start_i         start pulse, sampled only in IDLE
//   range_i         iterations per loop (0 behaves as 1)
//   base_i          initial offset per channel
//   stride_i        per-channel, per-loop two's-complement jump
//   valid_o/ready_i output handshake
//   offs_o, idx_o   current offsets and loop indices
//   last_o          bit l set when loops 0..l are all at their final index
//   busy_o          high while running
//   done_o          one-cycle pulse after the final beat
// -----------------------------------------------------------------------------
module hwpe_ctrl_nloop #(
    parameter int unsigned NB_LOOPS   = 4,
    parameter int unsigned NB_CH      = 2,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned OFFS_WIDTH = 32
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         clear_i,
    input  logic                                         start_i,
    input  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]           range_i,
    input  logic [NB_CH-1:0][OFFS_WIDTH-1:0]             base_i,
    input  logic [NB_CH-1:0][NB_LOOPS-1:0][OFFS_WIDTH-1:0] stride_i,
    output logic                                         valid_o,
    input  logic                                         ready_i,
    output logic [NB_CH-1:0][OFFS_WIDTH-1:0]             offs_o,
    output logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]           idx_o,
    output logic [NB_LOOPS-1:0]                          last_o,
    output logic                                         busy_o,
    output logic                                         done_o
);

    localparam int unsigned LVL_W = (NB_LOOPS > 1) ? $clog2(NB_LOOPS) : 1;

    typedef enum logic {IDLE, RUN} state_e;

    state_e                                         state_q;
    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]             range_q;
    logic [NB_CH-1:0][NB_LOOPS-1:0][OFFS_WIDTH-1:0] stride_q;
    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]             idx_q, idx_d;
    logic [NB_CH-1:0][OFFS_WIDTH-1:0]               offs_q, offs_d;
    logic                                           valid_q, busy_q, done_q;

    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]             range_eff;
    logic [NB_LOOPS-1:0]                            at_end;
    logic [NB_LOOPS-1:0]                            last;
    logic                                           adv_found;
    logic [LVL_W-1:0]                               adv_lvl;

    // Effective ranges stored in the shadow registers, so 0 never reaches
    // the counter compare logic.
    // NOTE: every variable written in always_comb is given a value on every
    // path (here via the loop) so no latch is inferred.
    always_comb begin
        for (int l = 0; l < NB_LOOPS; l++) begin
            range_eff[l] = (range_i[l] == '0) ? CNT_WIDTH'(1) : range_i[l];
        end
    end

    // Per-loop "at final index" flags and the cumulative last decode.
    always_comb begin
        for (int l = 0; l < NB_LOOPS; l++) begin
            at_end[l] = (idx_q[l] == range_q[l] - CNT_WIDTH'(1));
        end
        last[0] = at_end[0];
        for (int l = 1; l < NB_LOOPS; l++) begin
            last[l] = last[l-1] & at_end[l];
        end
    end

    // Lowest loop that can still increment; none found means final beat.
    always_comb begin
        adv_found = 1'b0;
        adv_lvl   = '0;
        for (int l = 0; l < NB_LOOPS; l++) begin
            if (!adv_found && !at_end[l]) begin
                adv_found = 1'b1;
                adv_lvl   = LVL_W'(l);
            end
        end
    end

    // Next iteration: inner loops wrap to 0, the advancing loop increments,
    // and each channel adds only the advancing loop's stride.
    always_comb begin
        for (int l = 0; l < NB_LOOPS; l++) begin
            if (LVL_W'(l) < adv_lvl) begin
                idx_d[l] = '0;
            end else if (LVL_W'(l) == adv_lvl) begin
                idx_d[l] = idx_q[l] + CNT_WIDTH'(1);
            end else begin
                idx_d[l] = idx_q[l];
            end
        end
        for (int ch = 0; ch < NB_CH; ch++) begin
            offs_d[ch] = offs_q[ch] + stride_q[ch][adv_lvl];
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the shadow config registers are reset like the rest so outputs
    // and last_o decode to a known all-zero state after reset or clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            range_q  <= '0;
            stride_q <= '0;
            idx_q    <= '0;
            offs_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (clear_i) begin
            state_q  <= IDLE;
            range_q  <= '0;
            stride_q <= '0;
            idx_q    <= '0;
            offs_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        range_q  <= range_eff;
                        stride_q <= stride_i;
                        idx_q    <= '0;
                        offs_q   <= base_i;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    if (ready_i) begin
                        if (adv_found) begin
                            idx_q  <= idx_d;
                            offs_q <= offs_d;
                        end else begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign offs_o  = offs_q;
    assign idx_o   = idx_q;
    assign last_o  = last;

endmodule

// File: tb/tb_hwpe_ctrl_nloop.sv
// -----------------------------------------------------------------------------
// tb_hwpe_ctrl_nloop
//
// Self-checking bench for hwpe_ctrl_nloop. A beat-number model predicts every
// tuple arithmetically: for beat n with P_l = product of ranges below loop l,
// idx[l] = (n / P_l) % r_l, loop l has advanced (n/P_l - n/P_{l+1}) times, and
// last[l] holds when (n+1) is a multiple of P_{l+1}. Directed runs pin the
// model with literal sequences; randomized runs stress backpressure, mid-run
// config changes and clears.
// -----------------------------------------------------------------------------
module tb_hwpe_ctrl_nloop;

    localparam int NL = 4;
    localparam int NC = 2;
    localparam int CW = 16;
    localparam int OW = 32;

    logic                            clk, rst_n;
    logic                            clear_i, start_i, ready_i;
    logic [NL-1:0][CW-1:0]           range_i;
    logic [NC-1:0][OW-1:0]           base_i;
    logic [NC-1:0][NL-1:0][OW-1:0]   stride_i;
    logic                            valid_o, busy_o, done_o;
    logic [NC-1:0][OW-1:0]           offs_o;
    logic [NL-1:0][CW-1:0]           idx_o;
    logic [NL-1:0]                   last_o;

    hwpe_ctrl_nloop #(
        .NB_LOOPS(NL), .NB_CH(NC), .CNT_WIDTH(CW), .OFFS_WIDTH(OW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_i), .start_i(start_i),
        .range_i(range_i), .base_i(base_i), .stride_i(stride_i),
        .valid_o(valid_o), .ready_i(ready_i), .offs_o(offs_o), .idx_o(idx_o),
        .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int unsigned       m_r[NL];
    logic [OW-1:0]     m_base[NC];
    logic [OW-1:0]     m_stride[NC][NL];
    longint            m_n, m_total;
    bit                m_run, m_done, m_zero;

    function automatic void model_tuple(input longint n,
                                        output logic [NC-1:0][OW-1:0] eo,
                                        output logic [NL-1:0][CW-1:0] ei,
                                        output logic [NL-1:0] el);
        longint p[NL+1];
        p[0] = 1;
        for (int l = 0; l < NL; l++) p[l+1] = p[l] * m_r[l];
        for (int l = 0; l < NL; l++) begin
            ei[l] = CW'((n / p[l]) % m_r[l]);
            el[l] = (((n + 1) % p[l+1]) == 0);
        end
        for (int ch = 0; ch < NC; ch++) begin
            eo[ch] = m_base[ch];
            for (int l = 0; l < NL; l++)
                eo[ch] = eo[ch] + m_stride[ch][l] * OW'(n / p[l] - n / p[l+1]);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_done = 0; m_zero = 1; m_n = 0;
        end else begin
            m_done = 0;
            if (clear_i) begin
                m_run = 0; m_zero = 1;
            end else if (!m_run) begin
                if (start_i) begin
                    m_total = 1;
                    for (int l = 0; l < NL; l++) begin
                        m_r[l] = (range_i[l] == 0) ? 1 : int'(range_i[l]);
                        m_total = m_total * m_r[l];
                    end
                    for (int ch = 0; ch < NC; ch++) begin
                        m_base[ch] = base_i[ch];
                        for (int l = 0; l < NL; l++) m_stride[ch][l] = stride_i[ch][l];
                    end
                    m_n = 0; m_run = 1; m_zero = 0;
                end
            end else if (ready_i) begin
                if (m_n == m_total - 1) begin
                    m_run = 0; m_done = 1;
                end else begin
                    m_n++;
                end
            end
        end
    end

    // Compare process: every cycle on the falling edge.
    always @(negedge clk) begin
        logic [NC-1:0][OW-1:0] eo;
        logic [NL-1:0][CW-1:0] ei;
        logic [NL-1:0]         el;
        check("valid", 128'(valid_o), 128'(m_run));
        check("busy",  128'(busy_o),  128'(m_run));
        check("done",  128'(done_o),  128'(m_done));
        if (m_run) begin
            model_tuple(m_n, eo, ei, el);
            check("offs", 128'(offs_o), 128'(eo));
            check("idx",  128'(idx_o),  128'(ei));
            check("last", 128'(last_o), 128'(el));
        end else if (m_zero) begin
            check("offs_zero", 128'(offs_o), 128'(0));
            check("idx_zero",  128'(idx_o),  128'(0));
            check("last_zero", 128'(last_o), 128'(0));
        end
    end

    // Beat capture for the literal checks.
    logic [OW-1:0] beat_offs[$];
    logic [NL-1:0] beat_last[$];
    always @(negedge clk) begin
        if (rst_n && valid_o && ready_i) begin
            beat_offs.push_back(offs_o[0]);
            beat_last.push_back(last_o);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int r0, r1, r2, r3, input logic [OW-1:0] b0,
                           input logic [OW-1:0] s0, s1);
        range_i = '0;
        range_i[0] = CW'(r0); range_i[1] = CW'(r1);
        range_i[2] = CW'(r2); range_i[3] = CW'(r3);
        base_i = '0;
        base_i[0] = b0;
        base_i[1] = 32'h0000_1000;
        stride_i = '0;
        stride_i[0][0] = s0; stride_i[0][1] = s1;
        stride_i[1][0] = 32'hFFFF_FFFD; stride_i[1][1] = 32'd7;
        stride_i[1][2] = 32'd11;        stride_i[1][3] = 32'd13;
    endtask

    task automatic start_run();
        beat_offs.delete();
        beat_last.delete();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (valid_o !== 1'b0 && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_ends"}, 128'(valid_o), 128'(0));
    endtask

    task automatic check_beats(input string tag, input int n,
                               input logic [OW-1:0] eo[6], input logic [1:0] el[6]);
        check({tag, "_nbeats"}, 128'(beat_offs.size()), 128'(n));
        for (int i = 0; i < n && i < beat_offs.size(); i++) begin
            check($sformatf("%s_offs%0d", tag, i), 128'(beat_offs[i]), 128'(eo[i]));
            check($sformatf("%s_last%0d", tag, i), 128'(beat_last[i][1:0]), 128'(el[i]));
        end
    endtask

    logic [OW-1:0] seq_offs[6] = '{32'd100, 32'd104, 32'd108, 32'd132, 32'd136, 32'd140};
    logic [1:0]    seq_last[6] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b11};
    logic [OW-1:0] wrap_offs[6] = '{32'hFFFF_FFFC, 32'h0000_0004, 0, 0, 0, 0};
    logic [1:0]    wrap_last[6] = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [OW-1:0] one_offs[6]  = '{32'h40, 0, 0, 0, 0, 0};
    logic [1:0]    one_last[6]  = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

    initial begin
        rst_n = 1'b0; clear_i = 1'b0; start_i = 1'b0; ready_i = 1'b1;
        range_i = '0; base_i = '0; stride_i = '0;
        tick(); tick();
        check("reset_valid", 128'(valid_o), 128'(0));
        check("reset_outs", 128'({offs_o, idx_o, last_o, busy_o, done_o}), 128'(0));
        rst_n = 1'b1;
        tick();

        // Basic 3x2 walk, ready always high.
        set_cfg(3, 2, 1, 1, 32'd100, 32'd4, 32'd24);
        start_run();
        wait_idle("basic", 50);
        check("basic_done", 128'(done_o), 128'(1));
        check_beats("basic", 6, seq_offs, seq_last);
        tick();

        // Backpressure: hold for 3 cycles after the first handshake.
        start_run();
        tick();
        ready_i = 1'b0;
        tick(); tick(); tick();
        check("hold_offs", 128'(offs_o[0]), 128'(104));
        check("hold_idx",  128'({idx_o[1], idx_o[0]}), 128'({16'd0, 16'd1}));
        ready_i = 1'b1;
        wait_idle("bp", 50);
        check("bp_done", 128'(done_o), 128'(1));
        check_beats("bp", 6, seq_offs, seq_last);
        tick();

        // Zero ranges behave as one: single beat, all last bits set.
        set_cfg(0, 1, 0, 0, 32'h40, 32'd4, 32'd24);
        start_run();
        check("one_last_all", 128'(last_o), 128'(4'hF));
        wait_idle("one", 20);
        check_beats("one", 1, one_offs, one_last);
        tick();

        // Clear after two beats, then a full rerun from base.
        set_cfg(3, 2, 1, 1, 32'd100, 32'd4, 32'd24);
        start_run();
        tick(); tick();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("clr_valid", 128'(valid_o), 128'(0));
        check("clr_done",  128'(done_o),  128'(0));
        tick();
        start_run();
        wait_idle("rerun", 50);
        check_beats("rerun", 6, seq_offs, seq_last);
        tick();

        // Clear together with start: nothing starts.
        clear_i = 1'b1; start_i = 1'b1;
        tick();
        clear_i = 1'b0; start_i = 1'b0;
        check("clrstart_valid", 128'(valid_o), 128'(0));
        tick();

        // 32-bit offset wrap.
        set_cfg(2, 1, 1, 1, 32'hFFFF_FFFC, 32'd8, 32'd0);
        start_run();
        wait_idle("wrap", 20);
        check_beats("wrap", 2, wrap_offs, wrap_last);
        tick();

        // Config changes and start pulses mid-run are ignored.
        set_cfg(3, 2, 1, 1, 32'd100, 32'd4, 32'd24);
        start_run();
        tick();
        set_cfg(4, 4, 4, 4, 32'd9999, 32'd1, 32'd1);
        start_i = 1'b1;
        tick(); tick();
        start_i = 1'b0;
        wait_idle("midcfg", 50);
        check_beats("midcfg", 6, seq_offs, seq_last);
        tick();

        // Asynchronous reset mid-run clears outputs immediately.
        set_cfg(3, 3, 2, 1, 32'd500, 32'd1, 32'd10);
        start_run();
        tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_outs", 128'({offs_o, idx_o, last_o, valid_o, busy_o, done_o}), 128'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized runs with backpressure, config noise and rare clears.
        for (int run = 0; run < 40; run++) begin
            for (int l = 0; l < NL; l++) range_i[l] = CW'($urandom_range(0, 3));
            for (int ch = 0; ch < NC; ch++) begin
                base_i[ch] = $urandom;
                for (int l = 0; l < NL; l++) stride_i[ch][l] = $urandom;
            end
            ready_i = ($urandom_range(0, 3) != 0);
            start_run();
            for (int k = 0; k < 400 && valid_o === 1'b1; k++) begin
                ready_i = ($urandom_range(0, 3) != 0);
                start_i = ($urandom_range(0, 7) == 0);
                clear_i = ($urandom_range(0, 99) == 0);
                if ($urandom_range(0, 3) == 0) begin
                    range_i[$urandom_range(0, NL-1)] = CW'($urandom);
                    base_i[$urandom_range(0, NC-1)] = $urandom;
                end
                tick();
            end
            start_i = 1'b0;
            clear_i = 1'b0;
            check("rand_ends", 128'(valid_o), 128'(0));
            tick();
        end

        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
